// File: rtl/veda_mem_arbiter.sv
// veda_mem_arbiter: shares the single-port veda_mem between the host port,
// the load/store port and the instruction-fetch port. Fixed priority
// host > data > fetch, with a counter that forces a fetch grant once
// fetch has been passed over STARVE_MAX times. Every access goes
// IDLE/RESP -> ACCESS -> RESP, and the owner gets its read data and a
// one-cycle ack on the edge that closes RESP.
module veda_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    // host port
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_ack,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic [1:0]        grant,
    output logic              busy
);

    // counter wide enough to hold STARVE_MAX itself
    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;
    localparam logic [1:0] GNT_H    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              acc_we_q, acc_we_d;      // current access is a write
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              h_ack_q, h_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] h_rdata_q, h_rdata_d;

    logic              if_mask_s, d_mask_s, h_mask_s;
    logic              if_elig_s, d_elig_s, h_elig_s;
    logic [1:0]        win_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Mask the port being acked: its req is still the old, already-served one.
    always_comb begin
        if_mask_s = 1'b0;
        d_mask_s  = 1'b0;
        h_mask_s  = 1'b0;
        case (state_q)
            ST_RESP: begin
                if_mask_s = (grant_q == GNT_IF);
                d_mask_s  = (grant_q == GNT_D);
                h_mask_s  = (grant_q == GNT_H);
            end
            ST_IDLE: begin
                if_mask_s = if_ack_q;
                d_mask_s  = d_ack_q;
                h_mask_s  = h_ack_q;
            end
            default: begin
                if_mask_s = 1'b0;
                d_mask_s  = 1'b0;
                h_mask_s  = 1'b0;
            end
        endcase
    end

    assign if_elig_s = if_req & ~if_mask_s;
    assign d_elig_s  = d_req  & ~d_mask_s;
    assign h_elig_s  = h_req  & ~h_mask_s;

    // Pick the winner at an arbitration point; the starvation override beats priority.
    always_comb begin
        win_s = GNT_NONE;
        if ((state_q == ST_IDLE) || (state_q == ST_RESP)) begin
            if ((starve_cnt_q == STARVE_LIM) && if_elig_s) begin
                win_s = GNT_IF;
            end else if (h_elig_s) begin
                win_s = GNT_H;
            end else if (d_elig_s) begin
                win_s = GNT_D;
            end else if (if_elig_s) begin
                win_s = GNT_IF;
            end else begin
                win_s = GNT_NONE;
            end
        end else begin
            win_s = GNT_NONE;
        end
    end

    // Route the winner's address, write enable and write data toward the memory.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        case (win_s)
            GNT_H: begin
                sel_we_s    = h_we;
                sel_addr_s  = h_addr;
                sel_wdata_s = h_wdata;
            end
            GNT_D: begin
                sel_we_s    = d_we;
                sel_addr_s  = d_addr;
                sel_wdata_s = d_wdata;
            end
            GNT_IF: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = if_addr;
                sel_wdata_s = {DATA_W{1'b0}};
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = {ADDR_W{1'b0}};
                sel_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Next state, response capture, access launch and starvation counting.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = {ADDR_W{1'b0}};
        mem_wdata_d  = {DATA_W{1'b0}};
        acc_we_d     = acc_we_q;
        starve_cnt_d = starve_cnt_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        h_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        h_rdata_d    = h_rdata_q;

        case (state_q)
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // mem_rdata is valid now; hand it to the owner with its ack
                case (grant_q)
                    GNT_IF: begin
                        if_ack_d = 1'b1;
                        if (!acc_we_q) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = if_rdata_q;
                        end
                    end
                    GNT_D: begin
                        d_ack_d = 1'b1;
                        if (!acc_we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                    GNT_H: begin
                        h_ack_d = 1'b1;
                        if (!acc_we_q) begin
                            h_rdata_d = mem_rdata;
                        end else begin
                            h_rdata_d = h_rdata_q;
                        end
                    end
                    default: begin
                        if_ack_d = 1'b0;
                    end
                endcase
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
                busy_d  = 1'b0;
            end
        endcase

        if (win_s != GNT_NONE) begin
            state_d     = ST_ACCESS;
            grant_d     = win_s;
            busy_d      = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we_s;
            mem_addr_d  = sel_addr_s;
            mem_wdata_d = sel_wdata_s;
            acc_we_d    = sel_we_s;
            if (win_s == GNT_IF) begin
                starve_cnt_d = {CNT_W{1'b0}};
            end else if (if_req && (starve_cnt_q < STARVE_LIM)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else if (state_q != ST_ACCESS) begin
            state_d = ST_IDLE;
            grant_d = GNT_NONE;
            busy_d  = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // State and output registers; reset returns every output to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            acc_we_q     <= 1'b0;
            starve_cnt_q <= {CNT_W{1'b0}};
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            h_ack_q      <= 1'b0;
            if_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q    <= {DATA_W{1'b0}};
            h_rdata_q    <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            acc_we_q     <= acc_we_d;
            starve_cnt_q <= starve_cnt_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            h_ack_q      <= h_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            h_rdata_q    <= h_rdata_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign h_ack     = h_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign h_rdata   = h_rdata_q;

endmodule

// File: tb/tb_veda_mem_arbiter.sv
// Self-checking bench for veda_mem_arbiter: a synchronous-read memory
// stands in for veda_mem, a transaction-level model predicts every output
// each cycle, and directed scenarios add hand-computed expectations.
module tb_veda_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          h_req = 1'b0, h_we = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic [DW-1:0] h_rdata;
    logic          h_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    grant;
    logic          busy;

    veda_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_ack(h_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    // synchronous-read single-port memory
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 no owner, 1 memory strobe cycle, 2 data-return cycle
    int            m_phase = 0;
    int            m_owner = 0;   // 1 fetch, 2 data, 3 host
    int            m_cnt   = 0;   // fetch pass-over count
    int            m_acked = 0;   // port whose ack is high this cycle
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rval  = '0;
    logic [DW-1:0] m_rdata [1:3];
    logic [DW-1:0] smem [0:(1<<AW)-1];

    function automatic int pick(input int mask);
        bit fe, de, he;
        fe = if_req && (mask != 1);
        de = d_req  && (mask != 2);
        he = h_req  && (mask != 3);
        if (fe && m_cnt == SM) return 1;
        if (he) return 3;
        if (de) return 2;
        if (fe) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_cnt = 0; m_acked = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        for (int k = 1; k <= 3; k++) m_rdata[k] = '0;
    endtask

    task automatic model_step();
        int mask;
        int w;
        if (m_phase == 1) begin
            m_phase = 2;
            m_acked = 0;
        end else begin
            if (m_phase == 2) begin
                if (!m_we) m_rdata[m_owner] = m_rval;
                mask    = m_owner;
                m_acked = m_owner;
            end else begin
                mask    = m_acked;
                m_acked = 0;
            end
            w = pick(mask);
            if (w != 0) begin
                m_phase = 1;
                m_owner = w;
                if (w == 3) begin m_we = h_we; m_addr = h_addr; m_wdata = h_wdata; end
                else if (w == 2) begin m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; end
                else begin m_we = 1'b0; m_addr = if_addr; m_wdata = '0; end
                if (m_we) smem[m_addr] = m_wdata;
                else      m_rval = smem[m_addr];
                if (w == 1)                      m_cnt = 0;
                else if (if_req && m_cnt < SM)   m_cnt = m_cnt + 1;
            end else begin
                m_phase = 0;
                m_owner = 0;
            end
        end
    endtask

    initial begin
        for (int k = 1; k <= 3; k++) m_rdata[k] = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // every-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("grant",     grant,     (m_phase != 0) ? m_owner : 0);
            chk("busy",      busy,      m_phase != 0);
            chk("mem_en",    mem_en,    m_phase == 1);
            chk("mem_we",    mem_we,    (m_phase == 1) && m_we);
            chk("mem_addr",  mem_addr,  (m_phase == 1) ? m_addr : '0);
            chk("mem_wdata", mem_wdata, (m_phase == 1) ? m_wdata : '0);
            chk("if_ack",    if_ack,    m_acked == 1);
            chk("d_ack",     d_ack,     m_acked == 2);
            chk("h_ack",     h_ack,     m_acked == 3);
            chk("if_rdata",  if_rdata,  m_rdata[1]);
            chk("d_rdata",   d_rdata,   m_rdata[2]);
            chk("h_rdata",   h_rdata,   m_rdata[3]);
        end
    end

    function automatic logic ack_of(input int p);
        case (p)
            1: return if_ack;
            2: return d_ack;
            default: return h_ack;
        endcase
    endfunction

    // one host (p=3) or data (p=2) access; returns ack latency and mem_we cycles
    task automatic port_txn(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, output int lat, output int we_cyc);
        bit done;
        done = 1'b0; lat = 0; we_cyc = 0;
        @(negedge clk);
        if (p == 3) begin h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd; end
        else        begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
        for (int i = 1; i <= 20 && !done; i++) begin
            @(posedge clk);
            #1;
            if (mem_we) we_cyc++;
            if (ack_of(p)) begin lat = i; done = 1'b1; end
        end
        chk("txn_timeout", done, 1'b1);
        @(negedge clk);
        if (p == 3) h_req = 1'b0;
        else        d_req = 1'b0;
    endtask

    logic [DW-1:0] w6;
    int            lat, wec;
    int            t_h, t_d, t_f, gi, gaps, si, nack;
    logic [1:0]    gseq [0:2];
    logic [1:0]    sseq [0:9];
    logic [1:0]    sexp [0:9];

    initial begin
        for (int k = 0; k < (1 << AW); k++) begin mem_arr[k] = '0; smem[k] = '0; end
        sexp = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01};

        // reset
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", grant, 2'b00);
        chk("post_rst_busy", busy, 1'b0);

        // single fetch of a preloaded instruction word
        w6 = {6'd11, 5'd12, 5'd1, 16'd0};
        mem_arr[6] = w6;
        smem[6]    = w6;
        @(negedge clk);
        if_req = 1'b1; if_addr = 10'd6;
        @(posedge clk); #1;
        chk("fetch_access_en", mem_en, 1'b1);
        chk("fetch_access_addr", mem_addr, 10'd6);
        chk("fetch_grant", grant, 2'b01);
        @(posedge clk); #1;
        chk("fetch_resp_grant", grant, 2'b01);
        chk("fetch_resp_busy", busy, 1'b1);
        @(posedge clk); #1;
        chk("fetch_ack", if_ack, 1'b1);
        chk("fetch_rdata", if_rdata, 32'h2D810000);
        @(negedge clk);
        if_req = 1'b0;
        @(posedge clk); #1;
        chk("fetch_ack_pulse", if_ack, 1'b0);
        chk("fetch_idle_grant", grant, 2'b00);

        // data write then read of word 512
        port_txn(2, 1'b1, 10'd512, 32'd34, lat, wec);
        chk("dwr_latency", lat, 3);
        chk("dwr_we_cycles", wec, 1);
        chk("dwr_rdata_held", d_rdata, 32'd0);
        port_txn(2, 1'b0, 10'd512, 32'd0, lat, wec);
        chk("drd_latency", lat, 3);
        chk("drd_we_cycles", wec, 0);
        chk("drd_rdata", d_rdata, 32'd34);

        // host write used later by contention
        port_txn(3, 1'b1, 10'd100, 32'hA5A50001, lat, wec);
        chk("hwr_rdata_held", h_rdata, 32'd0);

        // contention: all three ports at once
        @(negedge clk);
        h_req = 1'b1; h_we = 1'b0; h_addr = 10'd100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd512;
        if_req = 1'b1; if_addr = 10'd6;
        t_h = 0; t_d = 0; t_f = 0; gi = 0; gaps = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (mem_en && gi < 3) begin gseq[gi] = grant; gi++; end
            if (c <= 6 && !busy) gaps++;
            if (h_ack)  t_h = c;
            if (d_ack)  t_d = c;
            if (if_ack) t_f = c;
            @(negedge clk);
            if (h_ack)  h_req = 1'b0;
            if (d_ack)  d_req = 1'b0;
            if (if_ack) if_req = 1'b0;
        end
        chk("cont_h_ack_cycle", t_h, 3);
        chk("cont_d_ack_cycle", t_d, 5);
        chk("cont_f_ack_cycle", t_f, 7);
        chk("cont_grant0", gseq[0], 2'b11);
        chk("cont_grant1", gseq[1], 2'b10);
        chk("cont_grant2", gseq[2], 2'b01);
        chk("cont_idle_gaps", gaps, 0);
        chk("cont_h_rdata", h_rdata, 32'hA5A50001);
        chk("cont_f_rdata", if_rdata, 32'h2D810000);

        // starvation: host and data never let go, fetch held high
        @(negedge clk);
        h_req = 1'b1; d_req = 1'b1; if_req = 1'b1;
        si = 0;
        for (int c = 1; c <= 40 && si < 10; c++) begin
            @(posedge clk); #1;
            if (mem_en) begin sseq[si] = grant; si++; end
        end
        chk("starve_grant_count", si, 10);
        for (int k = 0; k < 10; k++) chk($sformatf("starve_grant%0d", k), sseq[k], sexp[k]);
        @(negedge clk);
        h_req = 1'b0; d_req = 1'b0; if_req = 1'b0;
        repeat (4) @(negedge clk);

        // reset during the ACCESS of a data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd512;
        @(posedge clk); #1;
        chk("rstmid_access_en", mem_en, 1'b1);
        chk("rstmid_access_grant", grant, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_mem_en", mem_en, 1'b0);
        chk("rstmid_mem_addr", mem_addr, 10'd0);
        chk("rstmid_grant", grant, 2'b00);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_d_rdata", d_rdata, 32'd0);
        chk("rstmid_h_rdata", h_rdata, 32'd0);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        nack = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (d_ack) nack++;
        end
        chk("rstmid_no_ack", nack, 0);
        port_txn(2, 1'b0, 10'd512, 32'd0, lat, wec);
        chk("rstmid_retry_latency", lat, 3);
        chk("rstmid_retry_rdata", d_rdata, 32'd34);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
